// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, state
// encodings, ALU/PC-source/reg-destination encodings and instruction classes.
package mc_control_unit_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SLTI = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_BLTZ = 6'b110110;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Bit 3 only distinguishes sHALT from sID; the debug State port shows [2:0].
  localparam logic [3:0] S_IF     = 4'b0000;
  localparam logic [3:0] S_ID     = 4'b0001;
  localparam logic [3:0] S_EXE_AL = 4'b0110;
  localparam logic [3:0] S_EXE_BR = 4'b0101;
  localparam logic [3:0] S_EXE_LS = 4'b0010;
  localparam logic [3:0] S_MEM    = 4'b0011;
  localparam logic [3:0] S_WB_AL  = 4'b0111;
  localparam logic [3:0] S_WB_LD  = 4'b0100;
  localparam logic [3:0] S_HALT   = 4'b1001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PCSRC_NEXT   = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_RS     = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [1:0] REGDST_R31 = 2'b00;
  localparam logic [1:0] REGDST_RT  = 2'b01;
  localparam logic [1:0] REGDST_RD  = 2'b10;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_BR,
    CLS_LS,
    CLS_J,
    CLS_JR,
    CLS_JAL,
    CLS_HALT
  } op_class_e;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit bundle: IR/ALU-flag inputs and every datapath control output.
interface mc_control_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       Op_code;
  logic             Zero;
  logic             Sign;
  logic             PCWre;
  logic             IRWre;
  logic             InsMemRW;
  logic             ALUSrcA;
  logic             ALUSrcB;
  logic             ExtSel;
  logic [2:0]       ALUOp;
  logic             RegWre;
  logic [1:0]       RegDst;
  logic             WrRegDSrc;
  logic             DBDataSrc;
  logic             mRD;
  logic             mWR;
  logic [1:0]       PCSrc;
  logic [2:0]       State;
  logic [CNT_W-1:0] Retired;

  modport master (
    input  Op_code, Zero, Sign,
    output PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
           RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc, State, Retired
  );

  modport slave (
    output Op_code, Zero, Sign,
    input  PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
           RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc, State, Retired
  );
endinterface

// File: rtl/mc_control_unit_decode.sv
// Combinational opcode decoder: instruction class plus the ALU-stage controls
// and write-back register destination for ALU instructions.
module mc_decode
  import mc_control_unit_pkg::*;
(
  input  logic [5:0] op,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic       ext_sel,
  output logic [1:0] reg_dst,
  output op_class_e  op_class
);

  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    ext_sel   = 1'b0;
    reg_dst   = REGDST_RD;
    op_class  = CLS_NOP;
    case (op)
      OP_ADD:  op_class = CLS_ALU;
      OP_SUB:  begin op_class = CLS_ALU; alu_op = ALU_SUB; end
      OP_ADDI: begin
        op_class = CLS_ALU; alu_src_b = 1'b1; ext_sel = 1'b1; reg_dst = REGDST_RT;
      end
      OP_OR:   begin op_class = CLS_ALU; alu_op = ALU_OR; end
      OP_AND:  begin op_class = CLS_ALU; alu_op = ALU_AND; end
      OP_ORI:  begin
        op_class = CLS_ALU; alu_op = ALU_OR; alu_src_b = 1'b1; reg_dst = REGDST_RT;
      end
      OP_SLL:  begin op_class = CLS_ALU; alu_op = ALU_SLL; alu_src_a = 1'b1; end
      OP_SLT:  begin op_class = CLS_ALU; alu_op = ALU_SLT; end
      OP_SLTI: begin
        op_class = CLS_ALU; alu_op = ALU_SLT; alu_src_b = 1'b1; ext_sel = 1'b1;
        reg_dst  = REGDST_RT;
      end
      OP_SW, OP_LW:             op_class = CLS_LS;
      OP_BEQ, OP_BNE, OP_BLTZ:  op_class = CLS_BR;
      OP_J:    op_class = CLS_J;
      OP_JR:   op_class = CLS_JR;
      OP_JAL:  op_class = CLS_JAL;
      OP_HALT: op_class = CLS_HALT;
      default: op_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB, drives all datapath
// controls and counts retired instructions (one per PCWre pulse).
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic           CLK,
  input  logic           Reset,
  mc_control_unit_if.master bus
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [2:0] dec_alu_op;
  logic       dec_src_a, dec_src_b, dec_ext;
  logic [1:0] dec_reg_dst;
  op_class_e  op_class;

  logic       pc_wre, ir_wre, ins_mem_rw, alu_src_a, alu_src_b, ext_sel;
  logic [2:0] alu_op;
  logic       reg_wre, wr_reg_d_src, db_data_src, m_rd, m_wr;
  logic [1:0] reg_dst, pc_src;
  logic       taken;

  mc_decode u_decode (
    .op        (bus.Op_code),
    .alu_op    (dec_alu_op),
    .alu_src_a (dec_src_a),
    .alu_src_b (dec_src_b),
    .ext_sel   (dec_ext),
    .reg_dst   (dec_reg_dst),
    .op_class  (op_class)
  );

  always_comb begin
    case (bus.Op_code)
      OP_BEQ:  taken = bus.Zero;
      OP_BNE:  taken = ~bus.Zero;
      OP_BLTZ: taken = bus.Sign;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_wre       = 1'b0;
    ir_wre       = 1'b0;
    ins_mem_rw   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    ext_sel      = 1'b0;
    alu_op       = ALU_ADD;
    reg_wre      = 1'b0;
    reg_dst      = REGDST_R31;
    wr_reg_d_src = 1'b0;
    db_data_src  = 1'b0;
    m_rd         = 1'b0;
    m_wr         = 1'b0;
    pc_src       = PCSRC_NEXT;
    case (state_q)
      S_IF: begin
        ins_mem_rw = 1'b1;
        ir_wre     = 1'b1;
        state_d    = S_ID;
      end
      S_ID: begin
        case (op_class)
          CLS_J:    begin pc_src = PCSRC_JUMP; pc_wre = 1'b1; state_d = S_IF; end
          CLS_JR:   begin pc_src = PCSRC_RS;   pc_wre = 1'b1; state_d = S_IF; end
          CLS_JAL:  begin
            reg_wre = 1'b1; reg_dst = REGDST_R31; pc_src = PCSRC_JUMP;
            pc_wre  = 1'b1; state_d = S_IF;
          end
          CLS_HALT: state_d = S_HALT;
          CLS_BR:   state_d = S_EXE_BR;
          CLS_LS:   state_d = S_EXE_LS;
          CLS_ALU:  state_d = S_EXE_AL;
          default:  begin pc_wre = 1'b1; state_d = S_IF; end
        endcase
      end
      S_EXE_AL: begin
        alu_op    = dec_alu_op;
        alu_src_a = dec_src_a;
        alu_src_b = dec_src_b;
        ext_sel   = dec_ext;
        state_d   = S_WB_AL;
      end
      S_WB_AL: begin
        reg_wre      = 1'b1;
        wr_reg_d_src = 1'b1;
        reg_dst      = dec_reg_dst;
        pc_wre       = 1'b1;
        state_d      = S_IF;
      end
      S_EXE_BR: begin
        alu_op  = ALU_SUB;
        ext_sel = 1'b1;
        pc_wre  = 1'b1;
        pc_src  = taken ? PCSRC_BRANCH : PCSRC_NEXT;
        state_d = S_IF;
      end
      S_EXE_LS: begin
        alu_src_b = 1'b1;
        ext_sel   = 1'b1;
        state_d   = S_MEM;
      end
      S_MEM: begin
        if (bus.Op_code == OP_LW) begin
          m_rd    = 1'b1;
          state_d = S_WB_LD;
        end else begin
          m_wr    = 1'b1;
          pc_wre  = 1'b1;
          state_d = S_IF;
        end
      end
      S_WB_LD: begin
        reg_wre      = 1'b1;
        reg_dst      = REGDST_RT;
        wr_reg_d_src = 1'b1;
        db_data_src  = 1'b1;
        m_rd         = 1'b1;
        pc_wre       = 1'b1;
        state_d      = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Reset masks every control combinationally so an aborted instruction
  // cannot write the register file or memory on the reset edge.
  assign bus.PCWre     = pc_wre       & ~Reset;
  assign bus.IRWre     = ir_wre       & ~Reset;
  assign bus.InsMemRW  = ins_mem_rw   & ~Reset;
  assign bus.ALUSrcA   = alu_src_a    & ~Reset;
  assign bus.ALUSrcB   = alu_src_b    & ~Reset;
  assign bus.ExtSel    = ext_sel      & ~Reset;
  assign bus.ALUOp     = Reset ? '0 : alu_op;
  assign bus.RegWre    = reg_wre      & ~Reset;
  assign bus.RegDst    = Reset ? '0 : reg_dst;
  assign bus.WrRegDSrc = wr_reg_d_src & ~Reset;
  assign bus.DBDataSrc = db_data_src  & ~Reset;
  assign bus.mRD       = m_rd         & ~Reset;
  assign bus.mWR       = m_wr         & ~Reset;
  assign bus.PCSrc     = Reset ? '0 : pc_src;
  assign bus.State     = state_q[2:0];
  assign bus.Retired   = retired_q;

  assign retired_d = retired_q + CNT_W'(pc_wre);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= S_IF;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: cycle-by-cycle vector table plus
// halt and mid-instruction reset sequences; a 3-bit-counter copy checks wrap.
module tb_mc_control_unit;

  localparam logic [5:0] T_ADD = 6'b000000, T_ORI = 6'b010010, T_SLL = 6'b011000;
  localparam logic [5:0] T_SLTI = 6'b100111, T_SW = 6'b110000, T_LW = 6'b110001;
  localparam logic [5:0] T_BEQ = 6'b110100, T_BNE = 6'b110101, T_BLTZ = 6'b110110;
  localparam logic [5:0] T_J = 6'b111000, T_JR = 6'b111001, T_JAL = 6'b111010;
  localparam logic [5:0] T_HALT = 6'b111111, T_UNDEF = 6'b101010;

  localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_EAL = 3'b110, ST_EBR = 3'b101;
  localparam logic [2:0] ST_ELS = 3'b010, ST_MEM = 3'b011, ST_WAL = 3'b111, ST_WLD = 3'b100;

  typedef struct packed {
    logic       pcwre;
    logic       irwre;
    logic       insmem;
    logic       srca;
    logic       srcb;
    logic       ext;
    logic [2:0] aluop;
    logic       regwre;
    logic [1:0] regdst;
    logic       wrsrc;
    logic       dbsrc;
    logic       mrd;
    logic       mwr;
    logic [1:0] pcsrc;
  } ctl_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       s;
    logic [2:0] st;
    ctl_t       ctl;
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    ctl_t        ctl;
    logic [31:0] ret;
  } exp_t;

  logic  clk;
  logic  rst;
  ctl_t  act;
  vec_t  vecs[$];
  exp_t  sb[$];
  int    checks;
  int    errors;
  int    row;
  logic [31:0] ret_model;

  mc_control_unit_if #(.CNT_W(32)) bus ();
  mc_control_unit_if #(.CNT_W(3))  bus3 ();

  mc_control_unit #(.CNT_W(32)) dut (.CLK(clk), .Reset(rst), .bus(bus.master));
  mc_control_unit #(.CNT_W(3))  dut3 (.CLK(clk), .Reset(rst), .bus(bus3.master));

  assign bus3.Op_code = bus.Op_code;
  assign bus3.Zero    = bus.Zero;
  assign bus3.Sign    = bus.Sign;

  assign act = {bus.PCWre, bus.IRWre, bus.InsMemRW, bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel,
                bus.ALUOp, bus.RegWre, bus.RegDst, bus.WrRegDSrc, bus.DBDataSrc,
                bus.mRD, bus.mWR, bus.PCSrc};

  always #5 clk = ~clk;

  function automatic ctl_t f_if();
    ctl_t c = '0;
    c.irwre = 1'b1; c.insmem = 1'b1;
    return c;
  endfunction

  function automatic ctl_t f_pc(input logic [1:0] src);
    ctl_t c = '0;
    c.pcwre = 1'b1; c.pcsrc = src;
    return c;
  endfunction

  function automatic ctl_t f_jal();
    ctl_t c = f_pc(2'b11);
    c.regwre = 1'b1; c.regdst = 2'b00; c.wrsrc = 1'b0;
    return c;
  endfunction

  function automatic ctl_t f_alu(input logic [2:0] op, input logic a, input logic b, input logic e);
    ctl_t c = '0;
    c.aluop = op; c.srca = a; c.srcb = b; c.ext = e;
    return c;
  endfunction

  function automatic ctl_t f_wb_al(input logic [1:0] dst);
    ctl_t c = f_pc(2'b00);
    c.regwre = 1'b1; c.wrsrc = 1'b1; c.regdst = dst;
    return c;
  endfunction

  function automatic ctl_t f_br(input logic [1:0] src);
    ctl_t c = f_pc(src);
    c.aluop = 3'b001; c.ext = 1'b1;
    return c;
  endfunction

  function automatic ctl_t f_ls();
    return f_alu(3'b000, 1'b0, 1'b1, 1'b1);
  endfunction

  function automatic ctl_t f_sw();
    ctl_t c = f_pc(2'b00);
    c.mwr = 1'b1;
    return c;
  endfunction

  function automatic ctl_t f_lw_mem();
    ctl_t c = '0;
    c.mrd = 1'b1;
    return c;
  endfunction

  function automatic ctl_t f_wb_ld();
    ctl_t c = f_pc(2'b00);
    c.regwre = 1'b1; c.regdst = 2'b01; c.wrsrc = 1'b1; c.dbsrc = 1'b1; c.mrd = 1'b1;
    return c;
  endfunction

  function automatic void v(input logic r, input logic [5:0] op, input logic z, input logic s,
                            input logic [2:0] st, input ctl_t c);
    vec_t x;
    x.rst = r; x.op = op; x.z = z; x.s = s; x.st = st; x.ctl = c;
    vecs.push_back(x);
  endfunction

  task automatic step(input logic r, input logic [5:0] op, input logic z, input logic s,
                      input logic [2:0] es, input ctl_t ec);
    exp_t e;
    rst = r; bus.Op_code = op; bus.Zero = z; bus.Sign = s;
    e.st = es; e.ctl = ec; e.ret = ret_model;
    sb.push_back(e);
    if (r) ret_model = '0;
    else if (ec.pcwre) ret_model = ret_model + 1;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (bus.State !== e.st) begin
      errors++;
      $display("FAIL state row %0d: got %b want %b", row, bus.State, e.st);
    end
    checks++;
    if (act !== e.ctl) begin
      errors++;
      $display("FAIL ctl row %0d: got %b want %b", row, act, e.ctl);
    end
    checks++;
    if (bus.Retired !== e.ret) begin
      errors++;
      $display("FAIL retired row %0d: got %0d want %0d", row, bus.Retired, e.ret);
    end
    checks++;
    if (bus3.Retired !== e.ret[2:0]) begin
      errors++;
      $display("FAIL retired_wrap row %0d: got %0d want %0d", row, bus3.Retired, e.ret[2:0]);
    end
    @(posedge clk);
    #1;
    row++;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    bus.Op_code = '0; bus.Zero = 1'b0; bus.Sign = 1'b0;
    checks = 0; errors = 0; row = 0; ret_model = '0;
    repeat (2) @(posedge clk);
    #1;

    v(1, T_ADD, 0, 0, ST_IF, '0);
    v(0, T_ADD, 0, 0, ST_IF, f_if());
    v(0, T_ADD, 0, 0, ST_ID, '0);
    v(0, T_ADD, 0, 0, ST_EAL, f_alu(3'b000, 0, 0, 0));
    v(0, T_ADD, 0, 0, ST_WAL, f_wb_al(2'b10));
    v(0, T_LW, 0, 0, ST_IF, f_if());
    v(0, T_LW, 0, 0, ST_ID, '0);
    v(0, T_LW, 0, 0, ST_ELS, f_ls());
    v(0, T_LW, 0, 0, ST_MEM, f_lw_mem());
    v(0, T_LW, 0, 0, ST_WLD, f_wb_ld());
    v(0, T_BEQ, 1, 0, ST_IF, f_if());
    v(0, T_BEQ, 1, 0, ST_ID, '0);
    v(0, T_BEQ, 1, 0, ST_EBR, f_br(2'b01));
    v(0, T_BEQ, 0, 0, ST_IF, f_if());
    v(0, T_BEQ, 0, 0, ST_ID, '0);
    v(0, T_BEQ, 0, 0, ST_EBR, f_br(2'b00));
    v(0, T_BLTZ, 0, 1, ST_IF, f_if());
    v(0, T_BLTZ, 0, 1, ST_ID, '0);
    v(0, T_BLTZ, 0, 1, ST_EBR, f_br(2'b01));
    v(0, T_BNE, 0, 0, ST_IF, f_if());
    v(0, T_BNE, 0, 0, ST_ID, '0);
    v(0, T_BNE, 0, 0, ST_EBR, f_br(2'b01));
    v(0, T_JAL, 0, 0, ST_IF, f_if());
    v(0, T_JAL, 0, 0, ST_ID, f_jal());
    v(0, T_UNDEF, 0, 0, ST_IF, f_if());
    v(0, T_UNDEF, 0, 0, ST_ID, f_pc(2'b00));
    v(0, T_J, 0, 0, ST_IF, f_if());
    v(0, T_J, 0, 0, ST_ID, f_pc(2'b11));
    v(0, T_JR, 0, 0, ST_IF, f_if());
    v(0, T_JR, 0, 0, ST_ID, f_pc(2'b10));
    v(0, T_ORI, 0, 0, ST_IF, f_if());
    v(0, T_ORI, 0, 0, ST_ID, '0);
    v(0, T_ORI, 0, 0, ST_EAL, f_alu(3'b011, 0, 1, 0));
    v(0, T_ORI, 0, 0, ST_WAL, f_wb_al(2'b01));
    v(0, T_SLL, 0, 0, ST_IF, f_if());
    v(0, T_SLL, 0, 0, ST_ID, '0);
    v(0, T_SLL, 0, 0, ST_EAL, f_alu(3'b010, 1, 0, 0));
    v(0, T_SLL, 0, 0, ST_WAL, f_wb_al(2'b10));
    v(0, T_SLTI, 0, 0, ST_IF, f_if());
    v(0, T_SLTI, 0, 0, ST_ID, '0);
    v(0, T_SLTI, 0, 0, ST_EAL, f_alu(3'b101, 0, 1, 1));
    v(0, T_SLTI, 0, 0, ST_WAL, f_wb_al(2'b01));
    v(0, T_SW, 0, 0, ST_IF, f_if());
    v(0, T_SW, 0, 0, ST_ID, '0);
    v(0, T_SW, 0, 0, ST_ELS, f_ls());
    v(0, T_SW, 0, 0, ST_MEM, f_sw());

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].s, vecs[i].st, vecs[i].ctl);

    // halt: parks with no PC writes and a frozen count until reset
    step(0, T_HALT, 0, 0, ST_IF, f_if());
    step(0, T_HALT, 0, 0, ST_ID, '0);
    for (int unsigned k = 0; k < 10; k++)
      step(0, T_HALT, 1, 1, ST_ID, '0);
    step(1, T_HALT, 0, 0, ST_ID, '0);

    // reset landing in sMEM of sw must suppress mWR and restart at sIF
    step(0, T_SW, 0, 0, ST_IF, f_if());
    step(0, T_SW, 0, 0, ST_ID, '0);
    step(0, T_SW, 0, 0, ST_ELS, f_ls());
    step(1, T_SW, 0, 0, ST_MEM, '0);
    step(0, T_SW, 0, 0, ST_IF, f_if());
    step(0, T_SW, 0, 0, ST_ID, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
